// File: rtl/mips_instr_encoder_if.sv
// Handshake bundle between the op producer, the MIPS instruction encoder and
// the instruction-memory loader. The slave modport is the encoder's view.
interface mips_instr_encoder_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   // producer -> encoder
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_op;
   logic [4:0]    in_rs;
   logic [4:0]    in_rt;
   logic [4:0]    in_rd;
   logic [15:0]   in_imm;
   logic [25:0]   in_target;

   // encoder -> loader
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [31:0]   out_addr;

   // status
   logic [CW-1:0] count;
   logic          err_illegal;

   modport master (
      output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, count, err_illegal
   );

   modport slave (
      input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
      output in_ready, out_valid, out_instr, out_addr, count, err_illegal
   );
endinterface

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: turns symbolic ops into 32-bit instruction words,
// buffers them in a small FIFO and streams {word, byte address} to the loader.
module mips_instr_encoder #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst,
   mips_instr_encoder_if.slave        bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_SLT  = 4'd4,
      OP_JR   = 4'd5,
      OP_ADDI = 4'd6,
      OP_LW   = 4'd7,
      OP_SW   = 4'd8,
      OP_BEQ  = 4'd9,
      OP_BNE  = 4'd10,
      OP_J    = 4'd11,
      OP_JAL  = 4'd12
   } op_e;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [31:0]   addr_q;
   logic          err_q;

   logic [31:0]   enc_word;
   logic          enc_legal;
   logic          accept;
   logic          push;
   logic          pop;

   // Combinational encoder: op enum plus fields -> 32-bit instruction word.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      enc_word  = '0;
      enc_legal = 1'b1;
      case (bus.in_op)
         OP_ADD:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h20};
         OP_SUB:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h22};
         OP_AND:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h24};
         OP_OR:   enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h25};
         OP_SLT:  enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2A};
         // JR carries only rs; whatever sits on rt/rd is dropped.
         OP_JR:   enc_word = {6'h00, bus.in_rs, 15'd0, 6'h08};
         OP_ADDI: enc_word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
         OP_LW:   enc_word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
         OP_SW:   enc_word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
         OP_BEQ:  enc_word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
         OP_BNE:  enc_word = {6'h05, bus.in_rs, bus.in_rt, bus.in_imm};
         OP_J:    enc_word = {6'h02, bus.in_target};
         OP_JAL:  enc_word = {6'h03, bus.in_target};
         default: enc_legal = 1'b0;
      endcase
   end

   // Handshakes. No bypass when full: in_ready depends on occupancy only.
   assign bus.in_ready  = (count_q != CW'(DEPTH));
   assign bus.out_valid = (count_q != '0);
   assign accept        = bus.in_valid & bus.in_ready;
   assign push          = accept & enc_legal;
   assign pop           = bus.out_valid & bus.out_ready;

   // FIFO storage write at the tail.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; out_instr is masked to zero while
      // empty, so stale contents are never observable.
      if (push) mem[wr_ptr] <= enc_word;
   end

   // Pointers, occupancy, output address and the illegal-op pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         addr_q  <= BASE_ADDR;
         err_q   <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop
         // samples pre-edge values regardless of statement order.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            addr_q <= addr_q + 32'd4;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         err_q <= accept & ~enc_legal;
      end
   end

   assign bus.out_instr   = bus.out_valid ? mem[rd_ptr] : 32'h0;
   assign bus.out_addr    = addr_q;
   assign bus.count       = count_q;
   assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: expected {word, addr} pairs are
// queued when an op is accepted and compared when the DUT hands a word out.
module tb_mips_instr_encoder;

   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam logic [31:0] W_BASE = 32'hFFFF_FFF8;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mips_instr_encoder_if #(.DEPTH(4)) bus ();
   mips_instr_encoder_if #(.DEPTH(4)) bus_w ();

   mips_instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   mips_instr_encoder #(.DEPTH(4), .BASE_ADDR(W_BASE)) u_dut_wrap (
      .clk (clk),
      .rst (rst),
      .bus (bus_w)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   exp_t        sb[$];
   logic [31:0] exp_addr = BASE;

   // Reference encoding, written from the opcode/funct table.
   function automatic logic [31:0] model_word(input logic [3:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [15:0] imm, input logic [25:0] tgt);
      case (op)
         4'd0:    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
         4'd1:    return {6'h00, rs, rt, rd, 5'd0, 6'h22};
         4'd2:    return {6'h00, rs, rt, rd, 5'd0, 6'h24};
         4'd3:    return {6'h00, rs, rt, rd, 5'd0, 6'h25};
         4'd4:    return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
         4'd5:    return {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
         4'd6:    return {6'h08, rs, rt, imm};
         4'd7:    return {6'h23, rs, rt, imm};
         4'd8:    return {6'h2B, rs, rt, imm};
         4'd9:    return {6'h04, rs, rt, imm};
         4'd10:   return {6'h05, rs, rt, imm};
         4'd11:   return {6'h02, tgt};
         4'd12:   return {6'h03, tgt};
         default: return 32'h0;
      endcase
   endfunction

   // Output monitor: scoreboard compare on every transfer, plus hold check
   // on any cycle following a stall.
   task automatic monitor();
      logic        stall_q = 1'b0;
      logic [31:0] si = '0;
      logic [31:0] sa = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_q = 1'b0;
            continue;
         end
         if (stall_q) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== si || bus.out_addr !== sa) begin
               bad++;
               $display("FAIL hold: got v=%b %h@%h want v=1 %h@%h",
                        bus.out_valid, bus.out_instr, bus.out_addr, si, sa);
            end
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_word: got %h@%h want nothing", bus.out_instr, bus.out_addr);
            end else begin
               e = sb.pop_front();
               if (bus.out_instr !== e.instr || bus.out_addr !== e.addr) begin
                  bad++;
                  $display("FAIL word: got %h@%h want %h@%h",
                           bus.out_instr, bus.out_addr, e.instr, e.addr);
               end
            end
         end
         stall_q = bus.out_valid && !bus.out_ready;
         si = bus.out_instr;
         sa = bus.out_addr;
      end
   endtask

   // Present one op, wait for acceptance, record expectation. Starts and ends
   // just after a rising edge; in_valid is dropped on return.
   task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                       input logic [31:0] exp_word);
      bit ok = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_op     = op;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_imm    = imm;
      bus.in_target = tgt;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got in_ready=0 want 1 (op=%0d)", op);
      end else if (op <= 4'd12) begin
         sb.push_back('{instr: exp_word, addr: exp_addr});
         exp_addr = exp_addr + 32'd4;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_rand(input bit legal_only);
      logic [3:0]  op;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] tgt;
      op  = legal_only ? 4'($urandom_range(0, 12)) : 4'($urandom_range(0, 15));
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rd  = 5'($urandom);
      imm = 16'($urandom);
      tgt = 26'($urandom);
      send(op, rs, rt, rd, imm, tgt, model_word(op, rs, rt, rd, imm, tgt));
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
         bad++;
         $display("FAIL empty_after_drain: got v=%b cnt=%0d want v=0 cnt=0", bus.out_valid, bus.count);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid    = 1'b0;
      bus.out_ready   = 1'b0;
      bus_w.in_valid  = 1'b0;
      bus_w.out_ready = 1'b0;
      sb.delete();
      exp_addr = BASE;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.err_illegal !== 1'b0 ||
          bus.out_addr !== BASE || bus.out_instr !== 32'h0) begin
         bad++;
         $display("FAIL reset_state: got v=%b cnt=%0d err=%b addr=%h instr=%h want 0/0/0/%h/0",
                  bus.out_valid, bus.count, bus.err_illegal, bus.out_addr, bus.out_instr, BASE);
      end
      do_reset();
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL ready_after_reset: got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_add();
      do_reset();
      bus.out_ready = 1'b1;
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL latency: got out_valid=%b want 1", bus.out_valid);
      end
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic test_sequence();
      do_reset();
      bus.out_ready = 1'b1;
      send(4'd6,  5'd0,  5'd8, 5'd0, 16'h0005, 26'h0, 32'h2008_0005);
      send(4'd7,  5'd29, 5'd4, 5'd0, 16'h0010, 26'h0, 32'h8FA4_0010);
      send(4'd10, 5'd1,  5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h1420_FFFF);
      drain();
   endtask

   task automatic test_jumps();
      do_reset();
      bus.out_ready = 1'b1;
      send(4'd12, 5'd9,  5'd9, 5'd9, 16'h1234, 26'h0000040, 32'h0C00_0040);
      send(4'd5,  5'd31, 5'd5, 5'd7, 16'hABCD, 26'h3FFFFFF, 32'h03E0_0008);
      send(4'd11, 5'd0,  5'd0, 5'd0, 16'h0,    26'h3FFFFFF, 32'h0BFF_FFFF);
      drain();
   endtask

   task automatic test_full();
      do_reset();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         send(4'd3, 5'(k), 5'(k + 1), 5'(k + 2), 16'h0, 26'h0,
              model_word(4'd3, 5'(k), 5'(k + 1), 5'(k + 2), 16'h0, 26'h0));
      bus.in_valid = 1'b1;
      bus.in_op    = 4'd1;
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b0 || bus.count !== 3'd4 || bus.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL full: got rdy=%b cnt=%0d v=%b want 0/4/1", bus.in_ready, bus.count, bus.out_valid);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL no_bypass: got in_ready=%b want 0", bus.in_ready);
      end
      @(posedge clk);
      #1;
      send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, model_word(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0));
      drain();
   endtask

   task automatic test_illegal();
      do_reset();
      bus.out_ready = 1'b0;
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820);
      send(4'd14, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0);
      @(negedge clk);
      total++;
      if (bus.err_illegal !== 1'b1 || bus.count !== 3'd1) begin
         bad++;
         $display("FAIL illegal_pulse: got err=%b cnt=%0d want 1/1", bus.err_illegal, bus.count);
      end
      @(negedge clk);
      total++;
      if (bus.err_illegal !== 1'b0) begin
         bad++;
         $display("FAIL illegal_width: got err=%b want 0", bus.err_illegal);
      end
      @(posedge clk);
      #1;
      send(4'd1, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, model_word(4'd1, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0));
      drain();
   endtask

   task automatic test_back_to_back();
      time t0;
      do_reset();
      bus.out_ready = 1'b1;
      t0 = $time;
      for (int k = 0; k < 12; k++) send_rand(1'b1);
      total++;
      if ($time - t0 != 120) begin
         bad++;
         $display("FAIL stream_rate: got %0t want 120 for 12 ops", $time - t0);
      end
      @(negedge clk);
      total++;
      if (bus.count !== 3'd1) begin
         bad++;
         $display("FAIL push_pop_count: got %0d want 1", bus.count);
      end
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 0; k < 24; k++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         send_rand(1'b0);
      end
      drain();
   endtask

   task automatic test_addr_wrap();
      logic [31:0] wa;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         bus_w.in_valid  = 1'b1;
         bus_w.in_op     = 4'd11;
         bus_w.in_target = 26'(k);
         @(posedge clk);
         #1;
      end
      bus_w.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (bus_w.count !== 3'd3) begin
         bad++;
         $display("FAIL wrap_count: got %0d want 3", bus_w.count);
      end
      @(posedge clk);
      #1;
      bus_w.out_ready = 1'b1;
      wa = W_BASE;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (bus_w.out_valid !== 1'b1 || bus_w.out_addr !== wa || bus_w.out_instr !== {6'h02, 26'(k)}) begin
            bad++;
            $display("FAIL addr_wrap: got v=%b %h@%h want 1 %h@%h",
                     bus_w.out_valid, bus_w.out_instr, bus_w.out_addr, {6'h02, 26'(k)}, wa);
         end
         wa = wa + 32'd4;
         @(posedge clk);
         #1;
      end
      bus_w.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_stream();
      do_reset();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) send_rand(1'b1);
      #3;
      rst = 1'b1;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.err_illegal !== 1'b0 || bus.out_addr !== BASE) begin
         bad++;
         $display("FAIL mid_reset: got v=%b cnt=%0d err=%b addr=%h want 0/0/0/%h",
                  bus.out_valid, bus.count, bus.err_illegal, bus.out_addr, BASE);
      end
      sb.delete();
      exp_addr = BASE;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      send(4'd8, 5'd3, 5'd4, 5'd0, 16'h0008, 26'h0, 32'h AC64_0008);
      drain();
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_op       = '0;
      bus.in_rs       = '0;
      bus.in_rt       = '0;
      bus.in_rd       = '0;
      bus.in_imm      = '0;
      bus.in_target   = '0;
      bus.out_ready   = 1'b0;
      bus_w.in_valid  = 1'b0;
      bus_w.in_op     = '0;
      bus_w.in_rs     = '0;
      bus_w.in_rt     = '0;
      bus_w.in_rd     = '0;
      bus_w.in_imm    = '0;
      bus_w.in_target = '0;
      bus_w.out_ready = 1'b0;
      fork
         monitor();
      join_none
      test_reset();
      test_single_add();
      test_sequence();
      test_jumps();
      test_full();
      test_illegal();
      test_back_to_back();
      test_backpressure();
      test_addr_wrap();
      test_reset_mid_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish want finish before 1ms");
      $fatal(1, "watchdog expired");
   end

endmodule
